wisc_trace_checker: RTL and testbench
=====================================

WISC_TRACE_CHECKER -- requirements
Module: wisc_trace_checker

Interface
REQ-001 SHALL have parameter ARCH_WIDTH, default 16, which is the datapath/address width.
REQ-002 SHALL have parameter REG_WIDTH, default 4, which is the register-number width.
REQ-003 SHALL have parameter DEPTH, default 8, which is the entry count of each internal queue (power of 2).
REQ-004 SHALL have parameter TIMEOUT, default 1024, which is the maximum cycles an observed record waits for an expected record.
REQ-005 SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 Halt, RegWrite, MemRead, MemWrite  input  1 each  retire events from the CPU writeback stage.
REQ-009 WriteRegister  input  REG_WIDTH  register being written.
REQ-010 WriteData, MemAddress, MemDataIn, MemDataOut  input  ARCH_WIDTH each  retire data and address.
REQ-011 exp_valid  input  1  golden-trace record offered.
REQ-012 exp_ready  output  1  checker accepts a golden record.
REQ-013 exp_type  input  2  record type: 0 REG, 1 LOAD, 2 STORE, 3 HALT.
REQ-014 exp_key, exp_data  input  ARCH_WIDTH each  register number or address, and value.
REQ-015 chk_done, chk_pass, chk_fail  output  1 each  completion status.
REQ-016 fail_code  output  3  failure cause.
REQ-017 fail_index, match_count  output  16 each  index of the failing record; count of matched records.

Function
REQ-018 SHALL implement states RUN, DONE, FAIL; reset enters RUN; DONE and FAIL are absorbing until rst.
REQ-019 SHALL, in RUN, form observed records each cycle in fixed order REG, LOAD, STORE, HALT:
- REG when RegWrite: key = zero-extended WriteRegister, data = WriteData.
- LOAD when MemRead: key = MemAddress, data = MemDataOut.
- STORE when MemWrite: key = MemAddress, data = MemDataIn.
- HALT when Halt: key = 0, data = 0.
REQ-020 SHALL keep a cycles-since-reset counter saturating at 4, and SHALL drop a REG record with WriteRegister==0 while counter<4 (post-reset NOP).
REQ-021 SHALL push all of a cycle's records (0-4) into the observed queue in the same edge, in order; if free slots < records, SHALL go to FAIL with fail_code=5 (overflow), no partial push.
REQ-022 SHALL accept a golden record into the expected queue on exp_valid&&exp_ready; exp_ready = (expected queue not full) && state==RUN.
REQ-023 SHALL, when both queue heads are valid in RUN, pop both in one cycle; a record captured at edge N is compared no earlier than cycle N+1.
REQ-024 SHALL compare in priority type, key, data; first difference gives FAIL with fail_code 1/2/3 respectively and fail_index=match_count.
REQ-025 SHALL increment match_count (saturating at 0xFFFF) on each match; a matched HALT SHALL move to DONE with chk_pass=1.
REQ-026 SHALL count cycles the observed head is valid while the expected queue is empty; reaching TIMEOUT SHALL give FAIL with fail_code=4; the count clears on any pop.
REQ-027 SHALL allow simultaneous push and pop on each queue in the same cycle; pointers wrap modulo DEPTH; occupancy stays exact.
REQ-028 SHALL ignore all retire inputs and exp_valid in DONE/FAIL; queues frozen; fail_code/fail_index hold.
REQ-029 chk_done SHALL be 1 in DONE or FAIL; chk_fail SHALL be 1 only in FAIL; chk_pass SHALL be 1 only in DONE.

Reset
REQ-030 rst SHALL, at the next edge including mid-compare, empty both queues and clear chk_done, chk_pass, chk_fail, fail_code, fail_index, match_count, the timeout counter and the cycles-since-reset counter; exp_ready=0 during rst.

Verification
REQ-031 Expected REG 3/0x0005, HALT; DUT RegWrite r3=0x0005 at cycle 5, Halt at cycle 7 -> chk_pass=1, match_count=2.
REQ-032 LW: RegWrite r2=0x1234 plus MemRead 0x0010/0x1234 same cycle; expected REG, LOAD -> matched on consecutive cycles, match_count=2, no fail.
REQ-033 Expected STORE 0x0020/0x00AA; DUT stores 0x00AB -> chk_fail=1, fail_code=3, fail_index=0.
REQ-034 RegWrite r0 at cycle 1 after reset release -> not queued; at cycle 6 -> queued and compared.
REQ-035 9 observed records with no expected input -> fail_code=5; separately, 1 record with none expected for 1024 cycles -> fail_code=4.
REQ-036 rst pulsed while both queues hold 3 entries -> next edge all outputs 0 and queues empty.

Source files
------------

// File: rtl/wisc_trace_checker.sv
// Lock-step trace checker: compares records retired by a WISC CPU against a golden trace
// and reports pass on a matched HALT or fail (mismatch, queue overflow, timeout).
module wisc_trace_checker #(
    parameter int ARCH_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Halt,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [REG_WIDTH-1:0]  WriteRegister,
    input  logic [ARCH_WIDTH-1:0] WriteData,
    input  logic [ARCH_WIDTH-1:0] MemAddress,
    input  logic [ARCH_WIDTH-1:0] MemDataIn,
    input  logic [ARCH_WIDTH-1:0] MemDataOut,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic [1:0]            exp_type,
    input  logic [ARCH_WIDTH-1:0] exp_key,
    input  logic [ARCH_WIDTH-1:0] exp_data,
    output logic                  chk_done,
    output logic                  chk_pass,
    output logic                  chk_fail,
    output logic [2:0]            fail_code,
    output logic [15:0]           fail_index,
    output logic [15:0]           match_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = 2 + 2 * ARCH_WIDTH;

    localparam logic [1:0] T_REG   = 2'd0;
    localparam logic [1:0] T_LOAD  = 2'd1;
    localparam logic [1:0] T_STORE = 2'd2;
    localparam logic [1:0] T_HALT  = 2'd3;

    typedef enum logic [1:0] {S_RUN, S_DONE, S_FAIL} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   obs_mem_q [DEPTH];
    logic [RW-1:0]   obs_mem_d [DEPTH];
    logic [RW-1:0]   exp_mem_q [DEPTH];
    logic [RW-1:0]   exp_mem_d [DEPTH];
    logic [PW-1:0]   obs_rd_q, obs_rd_d, obs_wr_q, obs_wr_d;
    logic [PW-1:0]   exp_rd_q, exp_rd_d, exp_wr_q, exp_wr_d;
    logic [CW-1:0]   obs_cnt_q, obs_cnt_d, exp_cnt_q, exp_cnt_d;
    logic [15:0]     match_cnt_q, match_cnt_d, fail_index_q, fail_index_d;
    logic [2:0]      fail_code_q, fail_code_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [2:0]      age_q, age_d;

    logic [RW-1:0]         rec [4];
    logic [CW-1:0]         n_rec;
    logic [CW-1:0]         obs_free;
    logic                  overflow, pop, tmo_hit, halt_match, exp_push;
    logic [2:0]            cmp_code;
    logic [RW-1:0]         obs_head, exp_head;
    logic [ARCH_WIDTH-1:0] reg_key;

    assign reg_key  = ARCH_WIDTH'(WriteRegister);
    assign obs_head = obs_mem_q[obs_rd_q];
    assign exp_head = exp_mem_q[exp_rd_q];

    assign exp_ready   = !rst && (state_q == S_RUN) && (exp_cnt_q != CW'(DEPTH));
    assign chk_done    = (state_q != S_RUN);
    assign chk_pass    = (state_q == S_DONE);
    assign chk_fail    = (state_q == S_FAIL);
    assign fail_code   = fail_code_q;
    assign fail_index  = fail_index_q;
    assign match_count = match_cnt_q;

    always_comb begin
        state_d      = state_q;
        obs_mem_d    = obs_mem_q;
        exp_mem_d    = exp_mem_q;
        obs_rd_d     = obs_rd_q;
        obs_wr_d     = obs_wr_q;
        obs_cnt_d    = obs_cnt_q;
        exp_rd_d     = exp_rd_q;
        exp_wr_d     = exp_wr_q;
        exp_cnt_d    = exp_cnt_q;
        match_cnt_d  = match_cnt_q;
        fail_code_d  = fail_code_q;
        fail_index_d = fail_index_q;
        tmo_d        = tmo_q;
        age_d        = age_q;
        for (int i = 0; i < 4; i++) rec[i] = '0;
        n_rec      = '0;
        obs_free   = CW'(DEPTH) - obs_cnt_q;
        overflow   = 1'b0;
        pop        = 1'b0;
        tmo_hit    = 1'b0;
        halt_match = 1'b0;
        exp_push   = 1'b0;
        cmp_code   = 3'd0;

        // Records are packed densely in the fixed order REG, LOAD, STORE, HALT.
        if (RegWrite && !(WriteRegister == '0 && age_q < 3'd4)) begin
            rec[n_rec[1:0]] = {T_REG, reg_key, WriteData};
            n_rec = n_rec + CW'(1);
        end
        if (MemRead) begin
            rec[n_rec[1:0]] = {T_LOAD, MemAddress, MemDataOut};
            n_rec = n_rec + CW'(1);
        end
        if (MemWrite) begin
            rec[n_rec[1:0]] = {T_STORE, MemAddress, MemDataIn};
            n_rec = n_rec + CW'(1);
        end
        if (Halt) begin
            rec[n_rec[1:0]] = {T_HALT, {ARCH_WIDTH{1'b0}}, {ARCH_WIDTH{1'b0}}};
            n_rec = n_rec + CW'(1);
        end

        if (state_q == S_RUN) begin
            age_d    = (age_q == 3'd4) ? age_q : age_q + 3'd1;
            overflow = (obs_free < n_rec);
            exp_push = exp_valid && exp_ready;
            pop      = (obs_cnt_q != '0) && (exp_cnt_q != '0);

            if (!overflow) begin
                for (int i = 0; i < 4; i++) begin
                    if (CW'(i) < n_rec) obs_mem_d[obs_wr_q + PW'(i)] = rec[i];
                end
                obs_wr_d = obs_wr_q + n_rec[PW-1:0];
            end
            if (exp_push) begin
                exp_mem_d[exp_wr_q] = {exp_type, exp_key, exp_data};
                exp_wr_d = exp_wr_q + PW'(1);
            end

            if (pop) begin
                obs_rd_d = obs_rd_q + PW'(1);
                exp_rd_d = exp_rd_q + PW'(1);
                if (obs_head[RW-1 -: 2] != exp_head[RW-1 -: 2])
                    cmp_code = 3'd1;
                else if (obs_head[2*ARCH_WIDTH-1 -: ARCH_WIDTH] != exp_head[2*ARCH_WIDTH-1 -: ARCH_WIDTH])
                    cmp_code = 3'd2;
                else if (obs_head[ARCH_WIDTH-1:0] != exp_head[ARCH_WIDTH-1:0])
                    cmp_code = 3'd3;
                if (cmp_code == 3'd0) begin
                    match_cnt_d = (match_cnt_q == 16'hFFFF) ? match_cnt_q : match_cnt_q + 16'd1;
                    halt_match  = (obs_head[RW-1 -: 2] == T_HALT);
                end
            end

            obs_cnt_d = obs_cnt_q + (overflow ? CW'(0) : n_rec) - (pop ? CW'(1) : CW'(0));
            exp_cnt_d = exp_cnt_q + (exp_push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));

            // Timeout only runs while an observed record starves for a golden one.
            if (pop) begin
                tmo_d = '0;
            end else if (obs_cnt_q != '0 && exp_cnt_q == '0) begin
                tmo_d   = tmo_q + TW'(1);
                tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
            end

            if (cmp_code != 3'd0) begin
                state_d      = S_FAIL;
                fail_code_d  = cmp_code;
                fail_index_d = match_cnt_q;
            end else if (overflow) begin
                state_d      = S_FAIL;
                fail_code_d  = 3'd5;
                fail_index_d = match_cnt_q;
            end else if (tmo_hit) begin
                state_d      = S_FAIL;
                fail_code_d  = 3'd4;
                fail_index_d = match_cnt_q;
            end else if (halt_match) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        obs_mem_q <= obs_mem_d;
        exp_mem_q <= exp_mem_d;
        if (rst) begin
            state_q      <= S_RUN;
            obs_rd_q     <= '0;
            obs_wr_q     <= '0;
            obs_cnt_q    <= '0;
            exp_rd_q     <= '0;
            exp_wr_q     <= '0;
            exp_cnt_q    <= '0;
            match_cnt_q  <= '0;
            fail_code_q  <= '0;
            fail_index_q <= '0;
            tmo_q        <= '0;
            age_q        <= '0;
        end else begin
            state_q      <= state_d;
            obs_rd_q     <= obs_rd_d;
            obs_wr_q     <= obs_wr_d;
            obs_cnt_q    <= obs_cnt_d;
            exp_rd_q     <= exp_rd_d;
            exp_wr_q     <= exp_wr_d;
            exp_cnt_q    <= exp_cnt_d;
            match_cnt_q  <= match_cnt_d;
            fail_code_q  <= fail_code_d;
            fail_index_q <= fail_index_d;
            tmo_q        <= tmo_d;
            age_q        <= age_d;
        end
    end
endmodule

// File: tb/tb_wisc_trace_checker.sv
// Directed bench for wisc_trace_checker: each task drives one scenario and checks inline.
module tb_wisc_trace_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        Halt, RegWrite, MemRead, MemWrite;
    logic [3:0]  WriteRegister;
    logic [15:0] WriteData, MemAddress, MemDataIn, MemDataOut;
    logic        exp_valid, exp_ready;
    logic [1:0]  exp_type;
    logic [15:0] exp_key, exp_data;
    logic        chk_done, chk_pass, chk_fail;
    logic [2:0]  fail_code;
    logic [15:0] fail_index, match_count;

    int total = 0;
    int bad   = 0;

    wisc_trace_checker #(.ARCH_WIDTH(16), .REG_WIDTH(4), .DEPTH(8), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .Halt(Halt), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_type(exp_type),
        .exp_key(exp_key), .exp_data(exp_data), .chk_done(chk_done), .chk_pass(chk_pass),
        .chk_fail(chk_fail), .fail_code(fail_code), .fail_index(fail_index),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Halt = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        WriteRegister = 0; WriteData = 0; MemAddress = 0; MemDataIn = 0; MemDataOut = 0;
        exp_valid = 0; exp_type = 0; exp_key = 0; exp_data = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); tick(); tick(); rst = 0;
    endtask

    task automatic offer_exp(input logic [1:0] t, input logic [15:0] k, input logic [15:0] d);
        exp_valid = 1; exp_type = t; exp_key = k; exp_data = d;
    endtask

    task automatic push_exp(input logic [1:0] t, input logic [15:0] k, input logic [15:0] d);
        offer_exp(t, k, d); tick(); idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); tick();
        total++; if (chk_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d want=0", chk_done); end
        total++; if (chk_pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%0d want=0", chk_pass); end
        total++; if (chk_fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%0d want=0", chk_fail); end
        total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL reset_exp_ready got=%0d want=0", exp_ready); end
        total++; if (match_count !== 16'd0) begin bad++; $display("FAIL reset_match got=%0d want=0", match_count); end
        rst = 0; #1;
        total++; if (exp_ready !== 1'b1) begin bad++; $display("FAIL release_exp_ready got=%0d want=1", exp_ready); end
    endtask

    task automatic test_reg_halt();
        do_reset();
        push_exp(2'd0, 16'd3, 16'h0005);   // cycle 1
        push_exp(2'd3, 16'd0, 16'd0);      // cycle 2
        tick(); tick();                    // cycles 3,4
        RegWrite = 1; WriteRegister = 4'd3; WriteData = 16'h0005;
        tick(); idle_inputs();             // cycle 5
        tick();                            // cycle 6
        Halt = 1; tick(); idle_inputs();   // cycle 7
        for (int k = 0; k < 20 && !chk_done; k++) tick();
        total++; if (chk_pass !== 1'b1) begin bad++; $display("FAIL reg_halt_pass got=%0d want=1", chk_pass); end
        total++; if (chk_fail !== 1'b0) begin bad++; $display("FAIL reg_halt_fail got=%0d want=0", chk_fail); end
        total++; if (match_count !== 16'd2) begin bad++; $display("FAIL reg_halt_match got=%0d want=2", match_count); end
        RegWrite = 1; WriteRegister = 4'd5; WriteData = 16'h9; offer_exp(2'd1, 16'h1, 16'h2);
        tick(); idle_inputs(); tick();
        total++; if (match_count !== 16'd2 || chk_pass !== 1'b1 || exp_ready !== 1'b0) begin
            bad++; $display("FAIL done_absorb got=%0d/%0d/%0d want=2/1/0", match_count, chk_pass, exp_ready); end
    endtask

    task automatic test_lw();
        do_reset();
        push_exp(2'd0, 16'd2, 16'h1234);
        push_exp(2'd1, 16'h0010, 16'h1234);
        RegWrite = 1; WriteRegister = 4'd2; WriteData = 16'h1234;
        MemRead = 1; MemAddress = 16'h0010; MemDataOut = 16'h1234;
        tick(); idle_inputs();
        tick();
        total++; if (match_count !== 16'd1) begin bad++; $display("FAIL lw_first got=%0d want=1", match_count); end
        tick();
        total++; if (match_count !== 16'd2) begin bad++; $display("FAIL lw_second got=%0d want=2", match_count); end
        total++; if (chk_done !== 1'b0) begin bad++; $display("FAIL lw_done got=%0d want=0", chk_done); end
    endtask

    task automatic test_store_mismatch();
        do_reset();
        push_exp(2'd2, 16'h0020, 16'h00AA);
        MemWrite = 1; MemAddress = 16'h0020; MemDataIn = 16'h00AB; MemDataOut = 16'h00AA;
        tick(); idle_inputs();
        tick(); tick();
        total++; if (chk_fail !== 1'b1) begin bad++; $display("FAIL st_fail got=%0d want=1", chk_fail); end
        total++; if (fail_code !== 3'd3) begin bad++; $display("FAIL st_code got=%0d want=3", fail_code); end
        total++; if (fail_index !== 16'd0) begin bad++; $display("FAIL st_index got=%0d want=0", fail_index); end
        total++; if (chk_pass !== 1'b0 || chk_done !== 1'b1) begin
            bad++; $display("FAIL st_flags got=%0d/%0d want=0/1", chk_pass, chk_done); end
        Halt = 1; MemWrite = 1; offer_exp(2'd3, 16'd0, 16'd0);
        tick(); idle_inputs(); tick();
        total++; if (fail_code !== 3'd3 || chk_fail !== 1'b1 || exp_ready !== 1'b0) begin
            bad++; $display("FAIL fail_hold got=%0d/%0d/%0d want=3/1/0", fail_code, chk_fail, exp_ready); end
    endtask

    task automatic test_type_key();
        do_reset();
        push_exp(2'd1, 16'd3, 16'h0009);
        RegWrite = 1; WriteRegister = 4'd3; WriteData = 16'h0009;
        tick(); idle_inputs(); tick(); tick();
        total++; if (fail_code !== 3'd1 || chk_fail !== 1'b1) begin
            bad++; $display("FAIL type_code got=%0d/%0d want=1/1", fail_code, chk_fail); end
        do_reset();
        push_exp(2'd0, 16'd1, 16'h0011);
        push_exp(2'd0, 16'd2, 16'h0022);
        RegWrite = 1; WriteRegister = 4'd1; WriteData = 16'h0011; tick();
        WriteRegister = 4'd3; WriteData = 16'h0022; tick(); idle_inputs();
        tick(); tick();
        total++; if (fail_code !== 3'd2) begin bad++; $display("FAIL key_code got=%0d want=2", fail_code); end
        total++; if (fail_index !== 16'd1) begin bad++; $display("FAIL key_index got=%0d want=1", fail_index); end
    endtask

    task automatic test_nop_drop();
        do_reset();
        RegWrite = 1; WriteRegister = 4'd0; WriteData = 16'h0055;
        offer_exp(2'd0, 16'd0, 16'h0077);
        tick(); idle_inputs();             // cycle 1: r0 dropped
        repeat (4) tick();                 // cycles 2-5
        total++; if (chk_done !== 1'b0 || match_count !== 16'd0) begin
            bad++; $display("FAIL nop_dropped got=%0d/%0d want=0/0", chk_done, match_count); end
        RegWrite = 1; WriteRegister = 4'd0; WriteData = 16'h0077;
        tick(); idle_inputs();             // cycle 6: r0 queued
        tick();
        total++; if (match_count !== 16'd1 || chk_fail !== 1'b0) begin
            bad++; $display("FAIL nop_queued got=%0d/%0d want=1/0", match_count, chk_fail); end
    endtask

    task automatic test_overflow();
        do_reset();
        RegWrite = 1; WriteRegister = 4'd1; MemRead = 1; MemWrite = 1; Halt = 1;
        tick(); tick();                    // 8 records: exactly full
        idle_inputs();
        total++; if (chk_fail !== 1'b0) begin bad++; $display("FAIL ovf_full_ok got=%0d want=0", chk_fail); end
        RegWrite = 1; WriteRegister = 4'd2;
        tick(); idle_inputs();
        total++; if (chk_fail !== 1'b1 || fail_code !== 3'd5) begin
            bad++; $display("FAIL ovf_code got=%0d/%0d want=1/5", chk_fail, fail_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        RegWrite = 1; WriteRegister = 4'd5; WriteData = 16'h0001;
        tick(); idle_inputs();
        repeat (1023) tick();
        total++; if (chk_fail !== 1'b0) begin bad++; $display("FAIL tmo_early got=%0d want=0", chk_fail); end
        tick();
        total++; if (chk_fail !== 1'b1 || fail_code !== 3'd4) begin
            bad++; $display("FAIL tmo_code got=%0d/%0d want=1/4", chk_fail, fail_code); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            RegWrite = 1; WriteRegister = 4'(i + 1); WriteData = 16'(i * 3 + 1);
            offer_exp(2'd0, 16'(i + 1), 16'(i * 3 + 1));
            tick();
        end
        idle_inputs(); tick(); tick();
        total++; if (match_count !== 16'd12 || chk_fail !== 1'b0) begin
            bad++; $display("FAIL b2b_match got=%0d/%0d want=12/0", match_count, chk_fail); end
        Halt = 1; offer_exp(2'd3, 16'd0, 16'd0);
        tick(); idle_inputs(); tick();
        total++; if (chk_pass !== 1'b1 || match_count !== 16'd13) begin
            bad++; $display("FAIL b2b_halt got=%0d/%0d want=1/13", chk_pass, match_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        RegWrite = 1; WriteRegister = 4'd1; WriteData = 16'd1; offer_exp(2'd0, 16'd1, 16'd1);
        tick(); idle_inputs(); tick();
        total++; if (match_count !== 16'd1) begin bad++; $display("FAIL mid_pre got=%0d want=1", match_count); end
        push_exp(2'd0, 16'd7, 16'hF);
        push_exp(2'd0, 16'd8, 16'hF);
        push_exp(2'd0, 16'd9, 16'hF);
        RegWrite = 1; WriteRegister = 4'd2; WriteData = 16'd1;
        MemRead = 1; MemAddress = 16'h40; MemDataOut = 16'd2;
        MemWrite = 1; MemDataIn = 16'd3;
        tick();
        idle_inputs(); rst = 1;
        tick();
        total++; if ({chk_done, chk_pass, chk_fail, exp_ready} !== 4'b0 || fail_code !== 3'd0 ||
                     fail_index !== 16'd0 || match_count !== 16'd0) begin
            bad++; $display("FAIL mid_rst got=%b/%0d/%0d/%0d want=0000/0/0/0",
                            {chk_done, chk_pass, chk_fail, exp_ready}, fail_code, fail_index, match_count); end
        rst = 0;
        RegWrite = 1; WriteRegister = 4'd4; WriteData = 16'd4; offer_exp(2'd0, 16'd4, 16'd4);
        tick(); idle_inputs(); tick(); tick();
        total++; if (match_count !== 16'd1 || chk_fail !== 1'b0) begin
            bad++; $display("FAIL mid_empty got=%0d/%0d want=1/0", match_count, chk_fail); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_reg_halt();
        test_lw();
        test_store_mismatch();
        test_type_key();
        test_nop_drop();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
